// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: states, opcodes,
// ALU operations, PC source selects and the opcode class type.
package mc_ctrl_pkg;

  localparam int MC_OP_W    = 6;
  localparam int MC_STATE_W = 3;

  // FSM state codes (6 and 7 are unused and recover to IF)
  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  // PC source selects
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  // Instruction classes driving the FSM path
  typedef enum logic [2:0] {
    CL_ALU_R   = 3'd0,
    CL_ALU_I   = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_JUMP    = 3'd5,
    CL_HALT    = 3'd6,
    CL_UNKNOWN = 3'd7
  } op_class_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the ALU-side
// controls (operation, operand selects, immediate extension).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [MC_OP_W-1:0] opcode,
  output op_class_e          op_class,
  output logic [2:0]         alu_op,
  output logic               ext_sel,
  output logic               alu_src_a,
  output logic               alu_src_b
);

  // Map each opcode to its class and ALU configuration; unknown opcodes decode as a NOP
  always_comb begin
    op_class  = CL_UNKNOWN;
    alu_op    = ALU_ADD;
    ext_sel   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    case (opcode)
      OP_ADD:   begin op_class = CL_ALU_R; alu_op = ALU_ADD; end
      OP_SUB:   begin op_class = CL_ALU_R; alu_op = ALU_SUB; end
      OP_AND:   begin op_class = CL_ALU_R; alu_op = ALU_AND; end
      OP_SLT:   begin op_class = CL_ALU_R; alu_op = ALU_SLT; end
      OP_SLL:   begin op_class = CL_ALU_R; alu_op = ALU_SLL; alu_src_a = 1'b1; end
      OP_ADDIU: begin op_class = CL_ALU_I; alu_op = ALU_ADD; ext_sel = 1'b1; alu_src_b = 1'b1; end
      OP_ANDI:  begin op_class = CL_ALU_I; alu_op = ALU_AND; alu_src_b = 1'b1; end
      OP_ORI:   begin op_class = CL_ALU_I; alu_op = ALU_OR;  alu_src_b = 1'b1; end
      OP_XORI:  begin op_class = CL_ALU_I; alu_op = ALU_XOR; alu_src_b = 1'b1; end
      OP_SLTI:  begin op_class = CL_ALU_I; alu_op = ALU_SLT; ext_sel = 1'b1; alu_src_b = 1'b1; end
      OP_LW:    begin op_class = CL_LOAD;  alu_op = ALU_ADD; ext_sel = 1'b1; alu_src_b = 1'b1; end
      OP_SW:    begin op_class = CL_STORE; alu_op = ALU_ADD; ext_sel = 1'b1; alu_src_b = 1'b1; end
      // Branches compare via subtraction: zero for beq/bne, sign of rs-$0 for bltz
      OP_BEQ,
      OP_BNE,
      OP_BLTZ:  begin op_class = CL_BRANCH; alu_op = ALU_SUB; ext_sel = 1'b1; end
      OP_J,
      OP_JR,
      OP_JAL:   begin op_class = CL_JUMP; end
      OP_HALT:  begin op_class = CL_HALT; end
      default:  begin op_class = CL_UNKNOWN; end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle controller: walks each instruction through IF/ID/EXE/MEM/WB,
// pulses PCWre on the instruction's last cycle and drives datapath enables.
// Outputs are combinational from state and opcode and are held at 0 while
// Reset is asserted.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic [1:0]         PCSrc,
  output logic               IRWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               ExtSel,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               mRD,
  output logic               mWR,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] next_state_s;
  op_class_e          op_class_s;
  logic [2:0]         dec_alu_op_s;
  logic               dec_ext_sel_s;
  logic               dec_src_a_s;
  logic               dec_src_b_s;
  logic               br_taken_s;

  logic               pcwre_s;
  logic [1:0]         pcsrc_s;
  logic               irwre_s;
  logic               alusrca_s;
  logic               alusrcb_s;
  logic [2:0]         aluop_s;
  logic               extsel_s;
  logic               regwre_s;
  logic [1:0]         regdst_s;
  logic               wrregdsrc_s;
  logic               dbdatasrc_s;
  logic               mrd_s;
  logic               mwr_s;

  mc_ctrl_decode u_decode (
    .opcode    (opcode),
    .op_class  (op_class_s),
    .alu_op    (dec_alu_op_s),
    .ext_sel   (dec_ext_sel_s),
    .alu_src_a (dec_src_a_s),
    .alu_src_b (dec_src_b_s)
  );

  // Branch condition from ALU flags for the conditional-branch opcodes
  always_comb begin
    br_taken_s = 1'b0;
    case (opcode)
      OP_BEQ:  br_taken_s = zero;
      OP_BNE:  br_taken_s = ~zero;
      OP_BLTZ: br_taken_s = sign;
      default: br_taken_s = 1'b0;
    endcase
  end

  // Next-state selection by current state and instruction class
  always_comb begin
    next_state_s = S_IF;
    case (state_r)
      S_IF: next_state_s = S_ID;
      S_ID: begin
        case (op_class_s)
          CL_JUMP, CL_UNKNOWN: next_state_s = S_IF;
          CL_HALT:             next_state_s = S_HALT;
          default:             next_state_s = S_EXE;
        endcase
      end
      S_EXE: begin
        case (op_class_s)
          CL_LOAD, CL_STORE:   next_state_s = S_MEM;
          CL_ALU_R, CL_ALU_I:  next_state_s = S_WB;
          default:             next_state_s = S_IF;
        endcase
      end
      S_MEM: begin
        case (op_class_s)
          CL_LOAD: next_state_s = S_WB;
          default: next_state_s = S_IF;
        endcase
      end
      S_WB:    next_state_s = S_IF;
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_IF;
    endcase
  end

  // State register; asynchronous active-low reset returns to IF
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Per-state control outputs; IF and HALT never look at the opcode
  always_comb begin
    pcwre_s     = 1'b0;
    pcsrc_s     = PC_SEQ;
    irwre_s     = 1'b0;
    alusrca_s   = 1'b0;
    alusrcb_s   = 1'b0;
    aluop_s     = ALU_ADD;
    extsel_s    = 1'b0;
    regwre_s    = 1'b0;
    regdst_s    = 2'b00;
    wrregdsrc_s = 1'b0;
    dbdatasrc_s = 1'b0;
    mrd_s       = 1'b0;
    mwr_s       = 1'b0;
    case (state_r)
      S_IF: begin
        irwre_s = 1'b1;
      end
      S_ID: begin
        alusrca_s = dec_src_a_s;
        alusrcb_s = dec_src_b_s;
        aluop_s   = dec_alu_op_s;
        extsel_s  = dec_ext_sel_s;
        case (op_class_s)
          CL_JUMP: begin
            pcwre_s = 1'b1;
            case (opcode)
              OP_JR:   pcsrc_s = PC_JR;
              default: pcsrc_s = PC_JMP;
            endcase
            // jal links PC+4 into $31 during its single decode cycle
            if (opcode == OP_JAL) begin
              regwre_s    = 1'b1;
              regdst_s    = 2'b00;
              wrregdsrc_s = 1'b0;
            end else begin
              regwre_s    = 1'b0;
            end
          end
          CL_UNKNOWN: pcwre_s = 1'b1;
          default:    pcwre_s = 1'b0;
        endcase
      end
      S_EXE: begin
        alusrca_s = dec_src_a_s;
        alusrcb_s = dec_src_b_s;
        aluop_s   = dec_alu_op_s;
        extsel_s  = dec_ext_sel_s;
        if (op_class_s == CL_BRANCH) begin
          pcwre_s = 1'b1;
          pcsrc_s = br_taken_s ? PC_BR : PC_SEQ;
        end else begin
          pcwre_s = 1'b0;
        end
      end
      S_MEM: begin
        alusrca_s = dec_src_a_s;
        alusrcb_s = dec_src_b_s;
        aluop_s   = dec_alu_op_s;
        extsel_s  = dec_ext_sel_s;
        case (op_class_s)
          CL_LOAD:  mrd_s = 1'b1;
          CL_STORE: begin mwr_s = 1'b1; pcwre_s = 1'b1; end
          default:  mrd_s = 1'b0;
        endcase
      end
      S_WB: begin
        alusrca_s   = dec_src_a_s;
        alusrcb_s   = dec_src_b_s;
        aluop_s     = dec_alu_op_s;
        extsel_s    = dec_ext_sel_s;
        pcwre_s     = 1'b1;
        regwre_s    = 1'b1;
        wrregdsrc_s = 1'b1;
        regdst_s    = (op_class_s == CL_ALU_R) ? 2'b10 : 2'b01;
        dbdatasrc_s = (op_class_s == CL_LOAD) ? 1'b1 : 1'b0;
      end
      default: begin
        pcwre_s = 1'b0;
      end
    endcase
  end

  // Every output is forced low while Reset is held
  assign PCWre     = Reset & pcwre_s;
  assign PCSrc     = {2{Reset}} & pcsrc_s;
  assign IRWre     = Reset & irwre_s;
  assign ALUSrcA   = Reset & alusrca_s;
  assign ALUSrcB   = Reset & alusrcb_s;
  assign ALUOp     = {3{Reset}} & aluop_s;
  assign ExtSel    = Reset & extsel_s;
  assign RegWre    = Reset & regwre_s;
  assign RegDst    = {2{Reset}} & regdst_s;
  assign WrRegDSrc = Reset & wrregdsrc_s;
  assign DBDataSrc = Reset & dbdatasrc_s;
  assign mRD       = Reset & mrd_s;
  assign mWR       = Reset & mwr_s;
  assign state     = state_r;

endmodule
